ibis_tmds_serializer: RTL and testbench

Parametrised N-channel, W-to-L symbol serializer for the TMDS output path. It accepts one parallel symbol per channel through a valid/ready handshake and buffers it for one symbol period. Each symbol leaves as LANE_WIDTH-bit lanes per enabled clock; a downstream DDR/SERDES primitive then takes the lanes to serial. When the producer falls behind, the block inserts a configurable idle symbol and flags underrun, so the link never emits stale data.

---
 rtl/ibis_tmds_serializer.sv | 114 +++++++++++
 tb/tb_ibis_tmds_serializer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ibis_tmds_serializer.sv
// N-channel symbol-to-lane serializer for the TMDS output path.
// One symbol set is buffered ahead of the shifters; an idle symbol is substituted when the producer falls behind.
module ibis_tmds_serializer #(
  parameter int                      SYMBOL_WIDTH = 10,
  parameter int                      LANE_WIDTH   = 2,
  parameter int                      CHANNELS     = 3,
  parameter logic [SYMBOL_WIDTH-1:0] IDLE_SYMBOL  = 10'b1101010100,
  parameter bit                      MSB_FIRST    = 1'b0
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             enable,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CHANNELS*SYMBOL_WIDTH-1:0] in_symbols,
  output logic [CHANNELS*LANE_WIDTH-1:0]   out_lanes,
  output logic                             out_sym_start,
  output logic                             underrun,
  input  logic                             clear_underrun
);

  localparam int BEATS  = SYMBOL_WIDTH / LANE_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // A lane width that does not tile the symbol would drop or repeat bits, so refuse to build.
  if ((SYMBOL_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lane_width
    $error("LANE_WIDTH must divide SYMBOL_WIDTH");
  end

  logic [BEAT_W-1:0]                beat_r;
  logic [CHANNELS*SYMBOL_WIDTH-1:0] hold_r;
  logic                             hold_valid_r;
  logic                             underrun_r;
  logic                             boundary_s;
  logic                             accept_s;

  // Boundary detection and input handshake.
  always_comb begin
    boundary_s = enable && (beat_r == LAST_BEAT);
    in_ready   = !hold_valid_r || boundary_s;
    accept_s   = in_valid && in_ready;
  end

  // Beat counter; reset to the last beat so the first enabled cycle loads a symbol.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_r <= LAST_BEAT;
    end else if (enable) begin
      if (beat_r == LAST_BEAT) begin
        beat_r <= '0;
      end else begin
        beat_r <= beat_r + BEAT_W'(1);
      end
    end else begin
      beat_r <= beat_r;
    end
  end

  // Hold register: a new accept in a boundary cycle replaces the symbol being handed off.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_r       <= '0;
      hold_valid_r <= 1'b0;
    end else if (accept_s) begin
      hold_r       <= in_symbols;
      hold_valid_r <= 1'b1;
    end else if (boundary_s) begin
      hold_r       <= hold_r;
      hold_valid_r <= 1'b0;
    end else begin
      hold_r       <= hold_r;
      hold_valid_r <= hold_valid_r;
    end
  end

  // Sticky underrun flag; a fresh idle insertion beats a coincident clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      underrun_r <= 1'b0;
    end else if (boundary_s && !hold_valid_r) begin
      underrun_r <= 1'b1;
    end else if (clear_underrun) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= underrun_r;
    end
  end

  assign underrun      = underrun_r;
  assign out_sym_start = (beat_r == '0);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYMBOL_WIDTH-1:0] shift_r;

    // Per-channel shifter: load at the boundary, otherwise advance one lane per enabled cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        shift_r <= '0;
      end else if (boundary_s) begin
        shift_r <= hold_valid_r ? hold_r[c*SYMBOL_WIDTH +: SYMBOL_WIDTH] : IDLE_SYMBOL;
      end else if (enable) begin
        shift_r <= MSB_FIRST ? (shift_r << LANE_WIDTH) : (shift_r >> LANE_WIDTH);
      end else begin
        shift_r <= shift_r;
      end
    end

    for (genvar k = 0; k < LANE_WIDTH; k++) begin : g_lane_bit
      assign out_lanes[c*LANE_WIDTH + k] = MSB_FIRST ? shift_r[SYMBOL_WIDTH-1-k] : shift_r[k];
    end
  end

endmodule

// File: tb/tb_ibis_tmds_serializer.sv
// Bench for ibis_tmds_serializer: default LSB-first 3-channel instance against a symbol-schedule model,
// plus a 1-bit MSB-first instance checked against literal serial sequences.
module tb_ibis_tmds_serializer;
  localparam int SW = 10;
  localparam int LW = 2;
  localparam int CH = 3;
  localparam int BEATS = SW / LW;
  localparam logic [SW-1:0] IDLE = 10'b1101010100;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic enable = 1'b0;
  logic in_valid = 1'b0;
  logic clear_underrun = 1'b0;
  logic in_ready;
  logic [CH*SW-1:0] in_symbols = '0;
  logic [CH*LW-1:0] out_lanes;
  logic out_sym_start, underrun;

  logic in_valid2 = 1'b0;
  logic in_ready2;
  logic [SW-1:0] in_symbols2 = '0;
  logic [0:0] out_lanes2;
  logic sym_start2, underrun2;

  ibis_tmds_serializer dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_symbols(in_symbols), .out_lanes(out_lanes), .out_sym_start(out_sym_start),
    .underrun(underrun), .clear_underrun(clear_underrun));

  ibis_tmds_serializer #(.SYMBOL_WIDTH(10), .LANE_WIDTH(1), .CHANNELS(1), .MSB_FIRST(1'b1)) dut_msb (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_symbols(in_symbols2), .out_lanes(out_lanes2), .out_sym_start(sym_start2),
    .underrun(underrun2), .clear_underrun(1'b0));

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Model: enabled cycles since reset, current symbol set being emitted, one-deep pending slot.
  int m_n;
  bit m_started, m_hold_v, m_under, m_acc;
  logic [CH*SW-1:0] m_hold, m_cur;
  logic [CH*SW-1:0] q[$];
  bit prod_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_started = 0; m_hold_v = 0; m_under = 0; m_acc = 0;
    m_hold = '0; m_cur = '0;
  endtask

  task automatic model_step();
    bit bnd, setu;
    bnd  = enable && (m_n % BEATS == 0);
    setu = 0;
    m_acc = in_valid && (!m_hold_v || bnd);
    if (enable) begin
      if (bnd) begin
        if (m_hold_v) m_cur = m_hold;
        else begin
          m_cur = {CH{IDLE}};
          setu = 1;
        end
        m_hold_v = 0;
      end
      m_n++;
      m_started = 1;
    end
    if (setu) m_under = 1;
    else if (clear_underrun) m_under = 0;
    if (m_acc) begin
      m_hold = in_symbols;
      m_hold_v = 1;
    end
  endtask

  task automatic check_model();
    logic [CH*LW-1:0] el;
    logic [SW-1:0] s;
    int j;
    el = '0;
    j = (m_n - 1) % BEATS;
    if (m_started) begin
      for (int c = 0; c < CH; c++) begin
        s = m_cur[c*SW +: SW];
        el[c*LW +: LW] = s[j*LW +: LW];
      end
    end
    chk("lanes", out_lanes, el);
    chk("sym_start", out_sym_start, m_started && (j == 0));
    chk("underrun", underrun, m_under);
    chk("in_ready", in_ready, !m_hold_v || (enable && (m_n % BEATS == 0)));
  endtask

  // One clock: present producer head, model the edge, check at the falling edge.
  task automatic cycle();
    if (prod_en && q.size() > 0) begin
      in_valid = 1'b1;
      in_symbols = q[0];
    end else begin
      in_valid = 1'b0;
    end
    @(posedge aclk);
    model_step();
    if (m_acc) void'(q.pop_front());
    @(negedge aclk);
    check_model();
    #1;
  endtask

  // Asynchronous reset with immediate checks, then idle-fill and MSB-first instance checks.
  task automatic reset_sequence();
    logic [1:0] idle_exp [5];
    int expa [10];
    int expb [10];
    idle_exp = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
    expa = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    expb = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    @(negedge aclk); #2;
    aresetn = 1'b0;
    in_valid = 1'b0; in_valid2 = 1'b0;
    model_reset(); q.delete();
    #1;
    chk("rst_lanes", out_lanes, 0);
    chk("rst_start", out_sym_start, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge aclk); #1;
    aresetn = 1'b1;
    enable = 1'b1; clear_underrun = 1'b0; prod_en = 1'b0;
    for (int p = 1; p <= 30; p++) begin
      if (p == 1) begin in_valid2 = 1'b1; in_symbols2 = 10'b1000000001; end
      if (p == 2) in_symbols2 = 10'b1000000011;
      if (p == 12) in_valid2 = 1'b0;
      cycle();
      if (p <= 5) begin
        chk("idle_lanes", out_lanes, {3{idle_exp[p-1]}});
        chk("idle_start", out_sym_start, p == 1);
        chk("idle_underrun", underrun, 1);
      end
      if (p == 1) chk("msb_underrun", underrun2, 1);
      if (p <= 10) chk("msb_ready", in_ready2, p == 10);
      if (p >= 11 && p <= 20) chk("msb_bit_a", out_lanes2, expa[p-11]);
      if (p >= 21) chk("msb_bit_b", out_lanes2, expb[p-21]);
      if (p >= 11) chk("msb_start", sym_start2, (p == 11) || (p == 21));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset_sequence();

    // Streaming 3FF, 000, 2AA on all channels; the second and third wait behind the hold register.
    cycle();
    q.push_back({3{10'h3FF}});
    q.push_back({3{10'h000}});
    q.push_back({3{10'h2AA}});
    prod_en = 1'b1;
    clear_underrun = 1'b1;
    cycle();
    clear_underrun = 1'b0;
    chk("stream_cleared", underrun, 0);
    for (int s = 1; s <= 19; s++) begin
      cycle();
      if (s <= 18) chk("stream_underrun", underrun, 0);
      else chk("stream_end_underrun", underrun, 1);
      if (s >= 4 && s <= 8) chk("stream_3ff", out_lanes, 6'b111111);
      if (s >= 9 && s <= 13) chk("stream_000", out_lanes, 6'b000000);
      if (s >= 14 && s <= 18) chk("stream_2aa", out_lanes, 6'b101010);
      if (s >= 4 && s <= 18) chk("stream_start", out_sym_start, (s == 4) || (s == 9) || (s == 14));
    end

    // Enable gap of three cycles while beat 2 of a real symbol is on the lanes.
    q.push_back(30'($urandom));
    q.push_back(30'($urandom));
    begin
      bit reached;
      reached = 0;
      for (int i = 0; i < 30 && !reached; i++) begin
        cycle();
        if (i >= 6 && (m_n - 1) % BEATS == 2) reached = 1;
      end
      chk("gap_reach", reached, 1);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    enable = 1'b1;
    for (int i = 0; i < 15; i++) cycle();

    // Randomised traffic: enable gaps, bursty producer, stray clears.
    for (int i = 0; i < 600; i++) begin
      enable = ($urandom % 8) != 0;
      prod_en = ($urandom % 4) != 0;
      clear_underrun = ($urandom % 10) == 0;
      if (($urandom % 5) == 0 && q.size() < 3) q.push_back(30'($urandom));
      cycle();
    end

    // Clear coinciding with an idle-load boundary: the set must win.
    enable = 1'b1; clear_underrun = 1'b0; prod_en = 1'b0; q.delete();
    begin
      bit reached;
      reached = 0;
      for (int i = 0; i < 20 && !reached; i++) begin
        if (!m_hold_v && (m_n % BEATS == 0)) reached = 1;
        else cycle();
      end
      chk("race_reach", reached, 1);
    end
    clear_underrun = 1'b1;
    cycle();
    chk("race_set_wins", underrun, 1);
    q.push_back(30'($urandom));
    prod_en = 1'b1;
    cycle();
    chk("race_clear_later", underrun, 0);
    clear_underrun = 1'b0;
    for (int i = 0; i < 8; i++) cycle();

    // Mid-run reset with a symbol buffered.
    q.push_back(30'($urandom));
    cycle();
    reset_sequence();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
